// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end of the pipeline.
// Contents:
//   XLEN       - datapath / PC width
//   NOP_INSTR  - bubble instruction (addi x0,x0,0)
//   OP_*       - major opcode constants seen by decode
//   if_id_t    - payload carried by the IF/ID pipeline register
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/pipe_reg_if_id.sv
// IF/ID pipeline register.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset; loads a bubble with pc=0, pc_plus4=4
//   en    - load d when high, hold when low
//   flush - load a bubble (instr=NOP, valid=0) while keeping pc/pc_plus4 from d;
//           takes priority over en
//   d     - incoming payload
//   q     - registered payload
module pipe_reg_if_id
  import riscv_pkg::*;
#(
  parameter logic [31:0] BUBBLE = riscv_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q.instr    <= BUBBLE;
      q.pc       <= '0;
      q.pc_plus4 <= XLEN'(4);
      q.valid    <= 1'b0;
    end else if (flush) begin
      // pc fields of a bubble are never consumed but are kept defined.
      q.instr    <= BUBBLE;
      q.pc       <= d.pc;
      q.pc_plus4 <= d.pc_plus4;
      q.valid    <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with the IF/ID register.
// Ports:
//   clk_i, rst_i              - clock and asynchronous active-high reset
//   stall_f_i                 - hold PC_F
//   stall_d_i                 - hold IF/ID
//   flush_d_i                 - turn IF/ID into a bubble
//   pc_src_i, pc_target_i     - redirect from EX (branch taken / JAL / JALR)
//   imem_addr_o, imem_rdata_i - combinational instruction memory port
//   instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o - IF/ID contents
//   op/funct3/funct7/rs1/rs2/rd_d_o            - field slices of instr_d_o
//   misaligned_o              - sticky: some redirect target had [1:0] != 0
//
// Control priority: a redirect beats both stalls (PC takes the target, IF/ID
// becomes a bubble); flush beats stall_d_i; otherwise stalls hold their
// register and everything else advances by one instruction per cycle.
module fetch_stage #(
  parameter int             XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_f_i,
  input  logic            stall_d_i,
  input  logic            flush_d_i,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc_plus4_d_o,
  output logic            valid_d_o,
  output logic [6:0]      op_d_o,
  output logic [2:0]      funct3_d_o,
  output logic            funct7_d_o,
  output logic [4:0]      rs1_d_o,
  output logic [4:0]      rs2_d_o,
  output logic [4:0]      rd_d_o,
  output logic            misaligned_o
);

  import riscv_pkg::*;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_f_plus4;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target_aligned;
  logic            target_misaligned;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  assign pc_f_plus4        = pc_f + XLEN'(4);
  assign target_aligned    = {pc_target_i[XLEN-1:2], 2'b00};
  assign target_misaligned = |pc_target_i[1:0];

  always_comb begin
    pc_next = pc_f_plus4;
    if (pc_src_i)       pc_next = target_aligned;
    else if (stall_f_i) pc_next = pc_f;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_f <= RESET_PC;
    else       pc_f <= pc_next;
  end

  // Sticky until reset; the PC still goes to the aligned target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                               misaligned_o <= 1'b0;
    else if (pc_src_i && target_misaligned)  misaligned_o <= 1'b1;
  end

  assign imem_addr_o = pc_f;

  always_comb begin
    if_id_d.instr    = imem_rdata_i;
    if_id_d.pc       = pc_f;
    if_id_d.pc_plus4 = pc_f_plus4;
    if_id_d.valid    = 1'b1;
  end

  // A redirect kills the instruction fetched down the wrong path.
  pipe_reg_if_id #(
    .BUBBLE (NOP_INSTR)
  ) u_if_id (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (~stall_d_i),
    .flush (flush_d_i | pc_src_i),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign instr_d_o    = if_id_q.instr;
  assign pc_d_o       = if_id_q.pc;
  assign pc_plus4_d_o = if_id_q.pc_plus4;
  assign valid_d_o    = if_id_q.valid;

  assign op_d_o     = instr_d_o[6:0];
  assign funct3_d_o = instr_d_o[14:12];
  assign funct7_d_o = instr_d_o[30];
  assign rs1_d_o    = instr_d_o[19:15];
  assign rs2_d_o    = instr_d_o[24:20];
  assign rd_d_o     = instr_d_o[11:7];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src = 1'b0;
  logic [31:0] pc_target = '0;
  logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, misaligned;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [4:0]  rs1, rs2, rd;

  // Instruction memory contents: a fixed word at 0, a scrambled pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h0100_0193) ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_f_i    (stall_f),
    .stall_d_i    (stall_d),
    .flush_d_i    (flush_d),
    .pc_src_i     (pc_src),
    .pc_target_i  (pc_target),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .instr_d_o    (instr_d),
    .pc_d_o       (pc_d),
    .pc_plus4_d_o (pc_plus4_d),
    .valid_d_o    (valid_d),
    .op_d_o       (op),
    .funct3_d_o   (funct3),
    .funct7_d_o   (funct7),
    .rs1_d_o      (rs1),
    .rs2_d_o      (rs2),
    .rd_d_o       (rd),
    .misaligned_o (misaligned)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural view of PC and the decode-side slot.
  logic [31:0] m_pc, m_instr, m_pcd;
  logic        m_valid, m_mis;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP_INSTR; m_pcd = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all(input string tag);
    logic [31:0] fields;
    chk({tag, "_pc_f"},   imem_addr,  m_pc);
    chk({tag, "_pc_d"},   pc_d,       m_pcd);
    chk({tag, "_pc4_d"},  pc_plus4_d, m_pcd + 32'd4);
    chk({tag, "_valid"},  {31'b0, valid_d},    {31'b0, m_valid});
    chk({tag, "_mis"},    {31'b0, misaligned}, {31'b0, m_mis});
    fields = {6'b0, m_instr[6:0], m_instr[14:12], m_instr[30],
              m_instr[19:15], m_instr[24:20], m_instr[11:7]};
    chk({tag, "_fields"}, {6'b0, op, funct3, funct7, rs1, rs2, rd}, fields);
  endtask

  // ---------------- driver: one clock with current inputs ----------------
  task automatic step(input string tag);
    logic [31:0] n_pc, n_instr, n_pcd;
    logic        n_valid;
    n_instr = m_instr; n_pcd = m_pcd; n_valid = m_valid;
    if (pc_src)       n_pc = {pc_target[31:2], 2'b00};
    else if (stall_f) n_pc = m_pc;
    else              n_pc = m_pc + 32'd4;
    if (flush_d || pc_src) begin
      n_instr = NOP_INSTR; n_valid = 1'b0; n_pcd = m_pc;
    end else if (!stall_d) begin
      n_instr = mem_word(m_pc); n_valid = 1'b1; n_pcd = m_pc;
    end
    if (pc_src && pc_target[1:0] != 2'b00) m_mis = 1'b1;
    exp_q.push_back(n_instr);
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_valid = n_valid;
    chk({tag, "_instr"}, instr_d, exp_q.pop_front());
    check_all(tag);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    pc_src = 1'b1; pc_target = tgt;
    step("redir");
    pc_src = 1'b0;
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    logic [31:0] held_instr;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", instr_d, NOP_INSTR);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_pc4_d", pc_plus4_d, 32'h4);
    chk("rst_valid", {31'b0, valid_d}, 32'h0);
    chk("rst_pc_f", imem_addr, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'h0);
    @(negedge clk) rst = 1'b0;

    // First fetch after reset.
    step("t1a");
    chk("t1_pc_d", pc_d, 32'h0);
    chk("t1_op", {25'b0, op}, 32'h13);
    chk("t1_rd", {27'b0, rd}, 32'h1);
    chk("t1_valid", {31'b0, valid_d}, 32'h1);
    step("t1b");
    chk("t1_pc_f8", imem_addr, 32'h8);

    // Sequential fetch across the top of the address space.
    redirect(32'hFFFF_FFF8);
    step("t2a"); chk("t2_pc0", imem_addr, 32'hFFFF_FFFC);
    step("t2b"); chk("t2_pc1", imem_addr, 32'h0000_0000);
    step("t2c"); chk("t2_pc2", imem_addr, 32'h0000_0004);

    // Joint stall at PC 0x10.
    redirect(32'h0000_000C);
    step("t3pre");
    held_instr = mem_word(32'hC);
    stall_f = 1'b1; stall_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step("t3s");
      chk("t3_pc_hold", imem_addr, 32'h10);
      chk("t3_pcd_hold", pc_d, 32'hC);
      chk("t3_instr_hold", instr_d, held_instr);
    end
    stall_f = 1'b0; stall_d = 1'b0;
    step("t3r");
    chk("t3_resume", imem_addr, 32'h14);
    chk("t3_resume_pcd", pc_d, 32'h10);

    // Redirect overrides stalls.
    stall_f = 1'b1; stall_d = 1'b1;
    redirect(32'h0000_0100);
    stall_f = 1'b0; stall_d = 1'b0;
    chk("t4_pc", imem_addr, 32'h100);
    chk("t4_bubble", instr_d, 32'h13);
    chk("t4_valid0", {31'b0, valid_d}, 32'h0);
    step("t4b");
    chk("t4_pcd", pc_d, 32'h100);
    chk("t4_valid1", {31'b0, valid_d}, 32'h1);

    // Flush alone.
    redirect(32'h0000_0020);
    flush_d = 1'b1;
    step("t5");
    flush_d = 1'b0;
    chk("t5_valid", {31'b0, valid_d}, 32'h0);
    chk("t5_pc", imem_addr, 32'h24);

    // Misaligned redirect, then asynchronous reset mid-cycle.
    redirect(32'h0000_0102);
    chk("t6_pc", imem_addr, 32'h100);
    chk("t6_mis", {31'b0, misaligned}, 32'h1);
    step("t6a");
    step("t6b");
    chk("t6_mis_hold", {31'b0, misaligned}, 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t6_rst_pc", imem_addr, 32'h0);
    chk("t6_rst_mis", {31'b0, misaligned}, 32'h0);
    chk("t6_rst_valid", {31'b0, valid_d}, 32'h0);
    chk("t6_rst_instr", instr_d, NOP_INSTR);
    @(negedge clk) rst = 1'b0;

    // Random control mix against the model.
    for (int i = 0; i < 400; i++) begin
      pc_src    = ($urandom_range(0, 9) == 0);
      pc_target = $urandom;
      stall_f   = ($urandom_range(0, 3) == 0);
      stall_d   = stall_f ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      flush_d   = ($urandom_range(0, 9) == 0);
      step("rnd");
    end
    pc_src = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode/control logic.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from sequential, branch/jump redirect, or stall.
- Registers the fetched instruction and presents opcode/funct3/funct7[5]/register fields to decode, with stall and flush support from the hazard logic.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush and reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_f_i  in  1  hold the PC.
- stall_d_i  in  1  hold the IF/ID register.
- flush_d_i  in  1  replace the IF/ID contents with a bubble.
- pc_src_i  in  1  redirect taken (branch taken, JAL, JALR), resolved in EX.
- pc_target_i  in  XLEN  redirect target address.
- imem_addr_o  out  XLEN  instruction-memory address (= PC_F).
- imem_rdata_i  in  32  instruction word; combinational read of imem_addr_o.
- instr_d_o  out  32  registered instruction.
- pc_d_o  out  XLEN  PC of instr_d_o.
- pc_plus4_d_o  out  XLEN  pc_d_o+4, used for the JAL/JALR link value.
- valid_d_o  out  1  instr_d_o is a real instruction, not a bubble.
- op_d_o  out  7  instr_d_o[6:0].
- funct3_d_o  out  3  instr_d_o[14:12].
- funct7_d_o  out  1  instr_d_o[30].
- rs1_d_o / rs2_d_o / rd_d_o  out  5 each  instr_d_o[19:15] / [24:20] / [11:7].
- misaligned_o  out  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async assert, sync release):
  - PC_F = RESET_PC.
  - instr_d_o = NOP_INSTR; pc_d_o = 0; pc_plus4_d_o = 4; valid_d_o = 0.
  - misaligned_o = 0.
  - Reset mid-stall or mid-redirect discards everything.
- PC update, priority high to low:
  1. pc_src_i: PC_F <= {pc_target_i[XLEN-1:2], 2'b00}. Overrides stall_f_i.
  2. stall_f_i: PC_F holds.
  3. Otherwise PC_F <= PC_F + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- imem_addr_o = PC_F combinationally. Fetch latency is 1 cycle: the word at PC_F appears on instr_d_o the cycle after the edge.
- IF/ID update, priority high to low:
  1. flush_d_i or pc_src_i: instr_d_o <= NOP_INSTR, valid_d_o <= 0. pc_d_o and pc_plus4_d_o load PC_F and PC_F+4 (don't-care values, kept defined). Flush wins over stall_d_i.
  2. stall_d_i: all IF/ID outputs hold.
  3. Otherwise load imem_rdata_i, PC_F and PC_F+4, and set valid_d_o <= 1.
- Field outputs are pure slices of instr_d_o; no extra latency. During a bubble, decode sees opcode 0010011 with rd = x0, which is harmless.
- Misalignment: when pc_src_i = 1 and pc_target_i[1:0] != 0, set misaligned_o <= 1. It stays set until reset. The PC still takes the aligned target.
- stall_f_i = 1 with stall_d_i = 0 is legal: IF/ID reloads the same word each cycle. The hazard unit normally asserts both together.
- Simultaneous pc_src_i and stall_f_i/stall_d_i: the redirect is taken, the PC changes, and IF/ID becomes a bubble.
- First cycle after reset release: valid_d_o = 0; the RESET_PC instruction is valid on the following cycle.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN
  - NOP_INSTR
  - opcode constants: OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111
  - if_id_t packed struct {instr, pc, pc_plus4, valid}
- One sub-module, pipe_reg_if_id: an IF/ID register with enable, flush, async reset and if_id_t as the payload.
- The PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset release, imem returns 32'h00500093 at address 0: next cycle pc_d_o = 0, op_d_o = 0010011, rd_d_o = 1, valid_d_o = 1; PC_F = 8 one cycle later.
- Straight-line fetch from PC 32'hFFFF_FFF8 for three cycles: PC_F sequence FFFF_FFFC, 0000_0000, 0000_0004.
- stall_f_i = stall_d_i = 1 for 2 cycles at PC 0x10: PC_F stays 0x10, instr_d_o/pc_d_o unchanged; resumes at 0x14 afterwards.
- pc_src_i = 1 with target 0x100 while stall_f_i = stall_d_i = 1: next cycle PC_F = 0x100, instr_d_o = 32'h00000013, valid_d_o = 0; the following cycle pc_d_o = 0x100, valid_d_o = 1.
- flush_d_i = 1 alone at PC 0x20: IF/ID becomes bubble (valid_d_o = 0), PC_F advances to 0x24.
- Redirect target 0x102: PC_F = 0x100 and misaligned_o = 1, holding through later cycles; rst_i asserted mid-cycle clears it and the PC asynchronously.
